// File: rtl/washing_machine_plant.sv
// -----------------------------------------------------------------------------
// washing_machine_plant
//
// Behavioural model of the physical washing machine. It takes the actuator
// commands of the washing_machine controller and produces that controller's
// sensor inputs, so the controller can run closed-loop in simulation or on
// the board. Any illegal actuator combination is detected and the first
// cause is latched as a sticky fault.
//
// Parameters:
//   FILL_CYCLES  valve-on cycles from empty to full
//   HEAT_CYCLES  heater-on cycles (full drum) from cold to hot
//   WASH_CYCLES  motor_wash cycles (full drum) until clean
//   SPIN_CYCLES  motor_spin cycles (empty drum) until dry
//
// Ports:
//   clk50m      in   system clock, 50 MHz
//   rst         in   synchronous active-high reset, highest priority
//   new_load    in   one-cycle pulse: fresh dirty, wet clothes loaded
//   door_lock, valve, heater,
//   motor_wash, motor_spin, pump
//               in   actuator commands from the controller
//   full        out  level at maximum
//   hot         out  temperature at target
//   clean       out  wash complete
//   dry         out  spin complete
//   level       out  current water level (debug)
//   fault       out  sticky illegal-actuator flag
//   fault_code  out  first fault cause, 0 = none
// -----------------------------------------------------------------------------
module washing_machine_plant #(
  parameter int FILL_CYCLES = 16,
  parameter int HEAT_CYCLES = 16,
  parameter int WASH_CYCLES = 32,
  parameter int SPIN_CYCLES = 32
) (
  input  logic                               clk50m,
  input  logic                               rst,
  input  logic                               new_load,
  input  logic                               door_lock,
  input  logic                               valve,
  input  logic                               heater,
  input  logic                               motor_wash,
  input  logic                               motor_spin,
  input  logic                               pump,
  output logic                               full,
  output logic                               hot,
  output logic                               clean,
  output logic                               dry,
  output logic [$clog2(FILL_CYCLES+1)-1:0]   level,
  output logic                               fault,
  output logic [2:0]                         fault_code
);

  localparam int LW = $clog2(FILL_CYCLES + 1);
  localparam int TW = $clog2(HEAT_CYCLES + 1);
  localparam int WW = $clog2(WASH_CYCLES + 1);
  localparam int SW = $clog2(SPIN_CYCLES + 1);

  localparam logic [LW-1:0] LVL_MAX  = LW'(FILL_CYCLES);
  localparam logic [TW-1:0] TEMP_MAX = TW'(HEAT_CYCLES);
  localparam logic [WW-1:0] WASH_MAX = WW'(WASH_CYCLES);
  localparam logic [SW-1:0] SPIN_MAX = SW'(SPIN_CYCLES);

  typedef enum logic {
    ST_OK,
    ST_FAULT
  } state_t;

  logic [LW-1:0] level_q, level_d;
  logic [TW-1:0] temp_q,  temp_d;
  logic [WW-1:0] wash_q,  wash_d;
  logic [SW-1:0] spin_q,  spin_d;
  state_t        state_q, state_d;
  logic [2:0]    code_q,  code_d;
  logic [2:0]    cause;

  // Physical model: counters for water level, temperature, wash and spin.
  // Clears key off the next level so a sensor drops on the same edge the
  // drum empties (hot) or gets wet again (dry).
  always_comb begin
    level_d = level_q;
    if (valve && !pump && level_q != LVL_MAX) begin
      level_d = level_q + LW'(1);
    end else if (pump && !valve && level_q != '0) begin
      level_d = level_q - LW'(1);
    end

    temp_d = temp_q;
    if (level_d == '0) begin
      temp_d = '0;
    end else if (heater && level_q == LVL_MAX && temp_q != TEMP_MAX) begin
      temp_d = temp_q + TW'(1);
    end

    wash_d = wash_q;
    if (new_load) begin
      wash_d = '0;
    end else if (motor_wash && !motor_spin && door_lock &&
                 level_q == LVL_MAX && wash_q != WASH_MAX) begin
      wash_d = wash_q + WW'(1);
    end

    spin_d = spin_q;
    if (new_load || level_d != '0) begin
      spin_d = '0;
    end else if (motor_spin && !motor_wash && door_lock &&
                 level_q == '0 && spin_q != SPIN_MAX) begin
      spin_d = spin_q + SW'(1);
    end
  end

  // Fault detection: lowest-numbered true cause wins.
  always_comb begin
    cause = 3'd0;
    if (motor_wash && motor_spin) begin
      cause = 3'd1;
    end else if ((valve || motor_wash || motor_spin) && !door_lock) begin
      cause = 3'd2;
    end else if (heater && level_q != LVL_MAX) begin
      cause = 3'd3;
    end else if (valve && level_q == LVL_MAX) begin
      cause = 3'd4;
    end else if (pump && level_q == '0 && !motor_spin) begin
      cause = 3'd5;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_OK: begin
        if (cause != 3'd0) begin
          state_d = ST_FAULT;
          code_d  = cause;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_OK;
      end
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      level_q <= '0;
      temp_q  <= '0;
      wash_q  <= '0;
      spin_q  <= '0;
      state_q <= ST_OK;
      code_q  <= 3'd0;
    end else begin
      level_q <= level_d;
      temp_q  <= temp_d;
      wash_q  <= wash_d;
      spin_q  <= spin_d;
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign full       = (level_q == LVL_MAX);
  assign hot        = (temp_q == TEMP_MAX);
  assign clean      = (wash_q == WASH_MAX);
  assign dry        = (spin_q == SPIN_MAX);
  assign level      = level_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_washing_machine_plant.sv
module tb_washing_machine_plant;

  logic       clk50m = 1'b0;
  logic       rst, new_load, door_lock, valve, heater, motor_wash, motor_spin, pump;
  logic       full, hot, clean, dry, fault;
  logic [4:0] level;
  logic [2:0] fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  washing_machine_plant #(
    .FILL_CYCLES(16), .HEAT_CYCLES(16), .WASH_CYCLES(32), .SPIN_CYCLES(32)
  ) dut (
    .clk50m(clk50m), .rst(rst), .new_load(new_load), .door_lock(door_lock),
    .valve(valve), .heater(heater), .motor_wash(motor_wash),
    .motor_spin(motor_spin), .pump(pump), .full(full), .hot(hot),
    .clean(clean), .dry(dry), .level(level), .fault(fault),
    .fault_code(fault_code)
  );

  always #10 clk50m = ~clk50m;

  // Actuator bits: {rst, new_load, door_lock, valve, heater, motor_wash, motor_spin, pump}
  localparam logic [7:0] A_RST = 8'h80, A_NL = 8'h40, A_DL = 8'h20, A_V = 8'h10,
                         A_H = 8'h08, A_MW = 8'h04, A_MS = 8'h02, A_P = 8'h01;
  // Sensor bits: {full, hot, clean, dry, fault}
  localparam logic [4:0] S_F = 5'h10, S_H = 5'h08, S_C = 5'h04, S_D = 5'h02, S_FT = 5'h01;

  typedef struct {
    int         n;
    logic [7:0] act;
    logic [4:0] lvl;
    logic [4:0] sens;
    logic [2:0] code;
    string      name;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int n, input logic [7:0] a, input logic [4:0] l,
                     input logic [4:0] s, input logic [2:0] c, input string nm);
    vec_t v;
    v.n = n; v.act = a; v.lvl = l; v.sens = s; v.code = c; v.name = nm;
    tv.push_back(v);
  endtask

  task automatic drive(input logic [7:0] a);
    {rst, new_load, door_lock, valve, heater, motor_wash, motor_spin, pump} = a;
  endtask

  task automatic step();
    @(posedge clk50m);
    #1;
  endtask

  task automatic check(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl=%0d fhcdf=%b code=%0d, expected lvl=%0d fhcdf=%b code=%0d",
               nm, got[12:8], got[7:3], got[2:0], exp[12:8], exp[7:3], exp[2:0]);
    end
  endtask

  function automatic logic [12:0] observed();
    return {level, full, hot, clean, dry, fault, fault_code};
  endfunction

  // Run one actuator pattern until a sensor condition, bounded by a budget;
  // returns the number of edges taken (budget+1 on timeout).
  task automatic run_until(input logic [7:0] a, input int which, input int budget,
                           output int cyc);
    logic done;
    drive(a);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc <= budget) begin
      step();
      cyc++;
      case (which)
        0: done = full;
        1: done = hot;
        2: done = clean;
        3: done = (level == 5'd0);
        default: done = dry;
      endcase
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    drive(8'h00);

    add(1,  A_RST,                    5'd0,  5'h00,             3'd0, "reset");
    add(15, A_DL|A_V,                 5'd15, 5'h00,             3'd0, "fill15");
    add(1,  A_DL|A_V,                 5'd16, S_F,               3'd0, "fill16_full");
    add(3,  A_DL,                     5'd16, S_F,               3'd0, "level_hold");
    add(15, A_DL|A_H,                 5'd16, S_F,               3'd0, "heat15");
    add(1,  A_DL|A_H,                 5'd16, S_F|S_H,           3'd0, "heat16_hot");
    add(2,  A_DL,                     5'd16, S_F|S_H,           3'd0, "hot_hold");
    add(31, A_DL|A_MW,                5'd16, S_F|S_H,           3'd0, "wash31");
    add(1,  A_DL|A_MW,                5'd16, S_F|S_H|S_C,       3'd0, "wash32_clean");
    add(1,  A_DL|A_NL,                5'd16, S_F|S_H,           3'd0, "newload_clean0");
    add(1,  A_DL|A_P,                 5'd15, S_H,               3'd0, "drain_full0");
    add(14, A_DL|A_P,                 5'd1,  S_H,               3'd0, "drain_to1");
    add(1,  A_DL|A_P,                 5'd0,  5'h00,             3'd0, "drain_hot0");
    add(31, A_DL|A_MS,                5'd0,  5'h00,             3'd0, "spin31");
    add(1,  A_DL|A_MS,                5'd0,  S_D,               3'd0, "spin32_dry");
    add(1,  A_DL|A_MS|A_P,            5'd0,  S_D,               3'd0, "pump_spin_empty");
    add(1,  A_DL|A_V,                 5'd1,  5'h00,             3'd0, "rewet_dry0");
    add(1,  A_DL|A_P,                 5'd0,  5'h00,             3'd0, "drain_again");
    add(32, A_DL|A_MS,                5'd0,  S_D,               3'd0, "spin_dry2");
    add(1,  A_DL|A_MS|A_NL,           5'd0,  5'h00,             3'd0, "newload_wins");
    add(1,  A_MW|A_MS,                5'd0,  S_FT,              3'd1, "fault_code1");
    add(1,  A_DL|A_H,                 5'd0,  S_FT,              3'd1, "fault_sticky");
    add(1,  A_RST,                    5'd0,  5'h00,             3'd0, "rst_clears_fault");
    add(1,  A_DL|A_H,                 5'd0,  S_FT,              3'd3, "fault_code3");
    add(1,  A_RST,                    5'd0,  5'h00,             3'd0, "rst2");
    add(1,  A_P,                      5'd0,  S_FT,              3'd5, "fault_code5");
    add(1,  A_RST,                    5'd0,  5'h00,             3'd0, "rst3");
    add(16, A_DL|A_V,                 5'd16, S_F,               3'd0, "refill");
    add(1,  A_DL|A_V,                 5'd16, S_F|S_FT,          3'd4, "fault_code4_sat");
    add(1,  A_RST|A_DL|A_V,           5'd0,  5'h00,             3'd0, "rst_priority");
    add(1,  A_DL|A_V,                 5'd1,  5'h00,             3'd0, "resume_after_rst");
    add(1,  A_V,                      5'd2,  S_FT,              3'd2, "fault_code2_model");
    add(1,  A_RST,                    5'd0,  5'h00,             3'd0, "rst4");

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].act);
      for (int k = 0; k < tv[i].n; k++) step();
      check(tv[i].name, observed(), {tv[i].lvl, tv[i].sens, tv[i].code});
    end

    // Closed-loop cycle as the controller would run it, done twice.
    for (int pass = 0; pass < 2; pass++) begin
      run_until(A_DL|A_V,  0, 100, cyc); check_int("loop_fill_edges",  cyc, 16);
      run_until(A_DL|A_H,  1, 100, cyc); check_int("loop_heat_edges",  cyc, 16);
      run_until(A_DL|A_MW, 2, 100, cyc); check_int("loop_wash_edges",  cyc, 32);
      run_until(A_DL|A_P,  3, 100, cyc); check_int("loop_drain_edges", cyc, 16);
      check("loop_drained", observed(), {5'd0, S_C, 3'd0});
      run_until(A_DL|A_MS, 4, 100, cyc); check_int("loop_spin_edges",  cyc, 32);
      drive(A_NL);
      step();
      check("loop_end", observed(), {5'd0, 5'h00, 3'd0});
      drive(8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
